uart_frame_assembler: RTL and testbench

- Byte-to-packet stage that sits between the UART byte receiver and the register mapper / protocol transmitter.
- Consumes single-byte strobes, hunts for the 0x55 0xAA header, and collects 11 body bytes (function byte plus 10 data bytes). It then checks a trailing CRC8.
- On a good frame it publishes the 11 bytes as a stable bus with a one-cycle pack_done. On a bad frame it reports the error without disturbing the previously published data.
- Also supplies the response_data code consumed by the transmit path.

---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/crc8_update.sv | 25 ++
 rtl/uart_frame_assembler.sv | 123 ++++++++++++
 tb/tb_uart_frame_assembler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants and FSM encoding for the UART frame assembler
// and the transmit-side CRC generator.
package uart_frame_pkg;

   localparam logic [7:0] HDR0     = 8'h55;
   localparam logic [7:0] HDR1     = 8'hAA;

   localparam logic [7:0] RSP_OK   = 8'h80;
   localparam logic [7:0] RSP_CRC  = 8'hE1;
   localparam logic [7:0] RSP_TMO  = 8'hE2;

   localparam logic [7:0] CRC_POLY = 8'h07;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR2 = 2'd1,
      BODY = 2'd2,
      CHK  = 2'd3
   } state_t;

endpackage

// File: rtl/crc8_update.sv
// Single-byte CRC8 step: MSB-first, no reflection, no final XOR.
// Purely combinational so a byte is absorbed in one cycle.
module crc8_update
   import uart_frame_pkg::*;
#(
   parameter logic [7:0] POLY = CRC_POLY
) (
   input  logic [7:0] crc_in,
   input  logic [7:0] data,
   output logic [7:0] crc_out
);

   logic [7:0] c;

   // Eight shift/XOR steps unrolled over the incoming byte
   always_comb begin
      c = crc_in ^ data;
      for (int i = 0; i < 8; i++) begin
         if (c[7]) c = {c[6:0], 1'b0} ^ POLY;
         else      c = {c[6:0], 1'b0};
      end
      crc_out = c;
   end

endmodule

// File: rtl/uart_frame_assembler.sv
// Hunts 55 AA headers in the UART byte stream, collects the body,
// checks CRC8 and publishes good frames on a stable bus.
module uart_frame_assembler
   import uart_frame_pkg::*;
#(
   parameter int         _BODY_BYTES  = 11,
   parameter int         _TIMEOUT_CYC = 50000,
   parameter logic [7:0] _CRC_POLY    = CRC_POLY
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic [7:0]                uart_data,
   input  logic                      uart_done,
   output logic [8*_BODY_BYTES-1:0]  rev_data,
   output logic                      pack_done,
   output logic                      crc_err,
   output logic                      timeout_err,
   output logic                      pack_ing,
   output logic [7:0]                pack_cnt,
   output logic [7:0]                response_data
);

   localparam int IW = (_BODY_BYTES > 1) ? $clog2(_BODY_BYTES) : 1;
   localparam int GW = (_TIMEOUT_CYC > 1) ? $clog2(_TIMEOUT_CYC) : 1;

   localparam logic [IW-1:0] IDX_LAST = IW'(_BODY_BYTES - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(_TIMEOUT_CYC - 1);

   state_t                          state;
   logic [IW-1:0]                   idx;
   logic [GW-1:0]                   gap;
   logic [7:0]                      crc;
   logic [7:0]                      crc_next;
   logic [_BODY_BYTES-1:0][7:0]     shadow;
   logic                            gap_expired;

   crc8_update #(
      .POLY    (_CRC_POLY)
   ) u_crc (
      .crc_in  (crc),
      .data    (uart_data),
      .crc_out (crc_next)
   );

   assign gap_expired = (gap == GAP_LAST);

   // Inter-byte gap counter; only meaningful while a frame is open
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         gap <= '0;
      end else if (uart_done || state == IDLE) begin
         gap <= '0;
      end else begin
         gap <= gap + 1'b1;
      end
   end

   // Frame FSM; a byte on the expiry cycle takes priority over timeout
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         crc           <= 8'h00;
         shadow        <= '0;
         rev_data      <= '0;
         pack_done     <= 1'b0;
         crc_err       <= 1'b0;
         timeout_err   <= 1'b0;
         pack_ing      <= 1'b0;
         pack_cnt      <= 8'h00;
         response_data <= 8'h00;
      end else begin
         pack_done   <= 1'b0;
         crc_err     <= 1'b0;
         timeout_err <= 1'b0;
         if (uart_done) begin
            unique case (state)
               IDLE: begin
                  if (uart_data == HDR0) begin
                     state    <= HDR2;
                     pack_ing <= 1'b1;
                  end
               end
               HDR2: begin
                  if (uart_data == HDR1) begin
                     state <= BODY;
                     idx   <= '0;
                     crc   <= 8'h00;
                  end else if (uart_data != HDR0) begin
                     state    <= IDLE;
                     pack_ing <= 1'b0;
                  end
               end
               BODY: begin
                  shadow[idx] <= uart_data;
                  crc         <= crc_next;
                  idx         <= idx + 1'b1;
                  if (idx == IDX_LAST) state <= CHK;
               end
               CHK: begin
                  state    <= IDLE;
                  pack_ing <= 1'b0;
                  if (uart_data == crc) begin
                     rev_data      <= shadow;
                     pack_done     <= 1'b1;
                     pack_cnt      <= pack_cnt + 8'd1;
                     response_data <= RSP_OK;
                  end else begin
                     crc_err       <= 1'b1;
                     response_data <= RSP_CRC;
                  end
               end
            endcase
         end else if (state != IDLE && gap_expired) begin
            state         <= IDLE;
            pack_ing      <= 1'b0;
            timeout_err   <= 1'b1;
            response_data <= RSP_TMO;
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler: header hunt, CRC,
// timeout boundary, reset mid-frame and 256 back-to-back frames.
module tb_uart_frame_assembler;

   localparam int NB  = 11;
   localparam int TMO = 1000;

   logic              clk;
   logic              rst_n;
   logic [7:0]        uart_data;
   logic              uart_done;
   logic [8*NB-1:0]   rev_data;
   logic              pack_done;
   logic              crc_err;
   logic              timeout_err;
   logic              pack_ing;
   logic [7:0]        pack_cnt;
   logic [7:0]        response_data;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses   = 0;
   logic [7:0] exp_cnt = 8'd0;

   uart_frame_assembler #(
      ._BODY_BYTES  (NB),
      ._TIMEOUT_CYC (TMO),
      ._CRC_POLY    (8'h07)
   ) dut (
      .sys_clk       (clk),
      .sys_rst_n     (rst_n),
      .uart_data     (uart_data),
      .uart_done     (uart_done),
      .rev_data      (rev_data),
      .pack_done     (pack_done),
      .crc_err       (crc_err),
      .timeout_err   (timeout_err),
      .pack_ing      (pack_ing),
      .pack_cnt      (pack_cnt),
      .response_data (response_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pack_done === 1'b1) pulses <= pulses + 1;
   end

   function automatic logic [7:0] crc_ref(input logic [NB-1:0][7:0] b);
      logic [7:0] c;
      c = 8'h00;
      for (int k = 0; k < NB; k++) begin
         c = c ^ b[k];
         for (int j = 0; j < 8; j++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
            else      c = {c[6:0], 1'b0};
         end
      end
      return c;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      uart_data = b;
      uart_done = 1'b1;
      @(posedge clk);
      #1;
      uart_done = 1'b0;
   endtask

   task automatic send_frame(input logic [NB-1:0][7:0] b,
                             input logic [7:0] c);
      send_byte(8'h55);
      send_byte(8'hAA);
      for (int k = 0; k < NB; k++) send_byte(b[k]);
      send_byte(c);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      n_checks++;
      if (rev_data !== '0 || pack_done !== 1'b0 || crc_err !== 1'b0 ||
          timeout_err !== 1'b0 || pack_ing !== 1'b0 ||
          pack_cnt !== 8'h00 || response_data !== 8'h00) begin
         n_fail++;
         $display("FAIL %s: rev=%h pd=%b ce=%b te=%b pi=%b cnt=%h rsp=%h required all zero",
                  tag, rev_data, pack_done, crc_err, timeout_err,
                  pack_ing, pack_cnt, response_data);
      end
   endtask

   task automatic test_reset();
      check_idle_outputs("reset_values");
   endtask

   task automatic test_zero_frame();
      send_frame('0, 8'h00);
      exp_cnt = exp_cnt + 8'd1;
      n_checks++;
      if (pack_done !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_pack_done: got %b required 1", pack_done);
      end
      n_checks++;
      if (rev_data !== '0) begin
         n_fail++;
         $display("FAIL zero_rev_data: got %h required 0", rev_data);
      end
      n_checks++;
      if (pack_cnt !== exp_cnt || response_data !== 8'h80) begin
         n_fail++;
         $display("FAIL zero_cnt_rsp: got %h/%h required %h/80",
                  pack_cnt, response_data, exp_cnt);
      end
      tick();
      n_checks++;
      if (pack_done !== 1'b0 || pack_ing !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_pulse_width: pd=%b pi=%b required 0/0",
                  pack_done, pack_ing);
      end
   endtask

   task automatic test_crc();
      logic [NB-1:0][7:0] b;
      b = '0;
      b[10] = 8'h01;
      send_frame(b, 8'h07);
      exp_cnt = exp_cnt + 8'd1;
      n_checks++;
      if (pack_done !== 1'b1 || rev_data[87:80] !== 8'h01) begin
         n_fail++;
         $display("FAIL crc_good: pd=%b byte10=%h required 1/01",
                  pack_done, rev_data[87:80]);
      end
      send_frame(b, 8'h08);
      n_checks++;
      if (crc_err !== 1'b1 || pack_done !== 1'b0 ||
          response_data !== 8'hE1) begin
         n_fail++;
         $display("FAIL crc_bad: ce=%b pd=%b rsp=%h required 1/0/E1",
                  crc_err, pack_done, response_data);
      end
      n_checks++;
      if (rev_data[87:80] !== 8'h01 || pack_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL crc_bad_hold: byte10=%h cnt=%h required 01/%h",
                  rev_data[87:80], pack_cnt, exp_cnt);
      end
      tick();
      n_checks++;
      if (crc_err !== 1'b0) begin
         n_fail++;
         $display("FAIL crc_err_width: got %b required 0", crc_err);
      end
   endtask

   task automatic test_resync();
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h55);
      n_checks++;
      if (pack_ing !== 1'b1) begin
         n_fail++;
         $display("FAIL resync_hdr0: pack_ing=%b required 1", pack_ing);
      end
      send_byte(8'h55);
      send_byte(8'hAA);
      for (int k = 0; k < NB; k++) send_byte(8'h00);
      send_byte(8'h00);
      exp_cnt = exp_cnt + 8'd1;
      n_checks++;
      if (pack_done !== 1'b1 || pack_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL resync_frame: pd=%b cnt=%h required 1/%h",
                  pack_done, pack_cnt, exp_cnt);
      end
   endtask

   task automatic test_timeout();
      send_byte(8'h55);
      send_byte(8'hAA);
      for (int k = 0; k < 5; k++) send_byte(8'h11 + 8'(k));
      repeat (TMO - 1) tick();
      n_checks++;
      if (timeout_err !== 1'b0 || pack_ing !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_early: te=%b pi=%b required 0/1",
                  timeout_err, pack_ing);
      end
      tick();
      n_checks++;
      if (timeout_err !== 1'b1 || response_data !== 8'hE2 ||
          pack_ing !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_fire: te=%b rsp=%h pi=%b required 1/E2/0",
                  timeout_err, response_data, pack_ing);
      end
      n_checks++;
      if (rev_data !== '0 || pack_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL tmo_hold: rev=%h cnt=%h required 0/%h",
                  rev_data, pack_cnt, exp_cnt);
      end
      tick();
      n_checks++;
      if (timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_width: got %b required 0", timeout_err);
      end
      send_frame('0, 8'h00);
      exp_cnt = exp_cnt + 8'd1;
      n_checks++;
      if (pack_done !== 1'b1 || response_data !== 8'h80) begin
         n_fail++;
         $display("FAIL tmo_recover: pd=%b rsp=%h required 1/80",
                  pack_done, response_data);
      end
   endtask

   task automatic test_coincide();
      send_byte(8'h55);
      send_byte(8'hAA);
      repeat (TMO - 1) tick();
      send_byte(8'h00);
      n_checks++;
      if (timeout_err !== 1'b0 || pack_ing !== 1'b1) begin
         n_fail++;
         $display("FAIL coincide_byte_wins: te=%b pi=%b required 0/1",
                  timeout_err, pack_ing);
      end
      for (int k = 1; k < NB; k++) send_byte(8'h00);
      send_byte(8'h00);
      exp_cnt = exp_cnt + 8'd1;
      n_checks++;
      if (pack_done !== 1'b1) begin
         n_fail++;
         $display("FAIL coincide_frame: pd=%b required 1", pack_done);
      end
   endtask

   task automatic test_data_header();
      logic [NB-1:0][7:0] b;
      for (int k = 0; k < NB; k++) b[k] = 8'h30 + 8'(k);
      b[0] = 8'h01;
      b[1] = 8'h55;
      b[2] = 8'hAA;
      send_frame(b, crc_ref(b));
      exp_cnt = exp_cnt + 8'd1;
      n_checks++;
      if (pack_done !== 1'b1 || rev_data !== b) begin
         n_fail++;
         $display("FAIL data_header: pd=%b rev=%h required 1/%h",
                  pack_done, rev_data, b);
      end
      n_checks++;
      if (pack_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL data_header_cnt: got %h required %h",
                  pack_cnt, exp_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int err_seen;
      err_seen = 0;
      send_byte(8'h55);
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'h02);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("reset_mid_async");
      exp_cnt = 8'd0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (crc_err !== 1'b0 || timeout_err !== 1'b0) err_seen++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (crc_err !== 1'b0 || timeout_err !== 1'b0) err_seen++;
      end
      n_checks++;
      if (err_seen != 0) begin
         n_fail++;
         $display("FAIL reset_mid_no_err: %0d error cycles required 0",
                  err_seen);
      end
      check_idle_outputs("reset_mid_after");
      send_frame('0, 8'h00);
      exp_cnt = exp_cnt + 8'd1;
      n_checks++;
      if (pack_done !== 1'b1 || pack_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL reset_mid_frame: pd=%b cnt=%h required 1/%h",
                  pack_done, pack_cnt, exp_cnt);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [NB-1:0][7:0] b;
      int base;
      b = '0;
      b[10] = 8'h01;
      base = pulses;
      for (int f = 1; f <= 256; f++) begin
         send_frame(b, 8'h07);
         exp_cnt = exp_cnt + 8'd1;
         if (f == 255) begin
            n_checks++;
            if (pack_cnt !== 8'h00) begin
               n_fail++;
               $display("FAIL b2b_wrap: got %h required 00", pack_cnt);
            end
         end
      end
      n_checks++;
      if (pack_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL b2b_cnt: got %h required %h", pack_cnt, exp_cnt);
      end
      tick();
      n_checks++;
      if (pulses - base != 256) begin
         n_fail++;
         $display("FAIL b2b_pulses: got %0d required 256", pulses - base);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      uart_data = 8'h00;
      uart_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      test_reset();
      test_zero_frame();
      test_crc();
      test_resync();
      test_timeout();
      test_coincide();
      test_data_header();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
